// File: rtl/fp_add_issue_if.sv
// Handshake bundle for the FP add issue stage: operand input, adder side-channel and result output.
interface fp_add_issue_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      add_a;
  logic [31:0]      add_b;
  logic [31:0]      add_sum;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       out_flags;

  modport master (
    output in_valid, in_a, in_b, in_tag, add_sum, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_result, out_tag, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_tag, add_sum, out_ready,
    output in_ready, add_a, add_b, out_valid, out_result, out_tag, out_flags
  );
endinterface

// File: rtl/fp_add_issue.sv
// Operand FIFO feeding an external combinational FP adder, with IEEE-754 special-case
// resolution and a registered, tagged result behind a valid/ready handshake.
module fp_add_issue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  fp_add_issue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic {S_EMPTY, S_FULL} out_state_t;

  out_state_t       state;
  logic [31:0]      mem_a   [DEPTH];
  logic [31:0]      mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             rdy_en;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic [31:0]      sel_result;
  logic [3:0]       sel_flags;

  // in_ready is held low until the first edge after reset release.
  assign fifo_empty   = (count == '0);
  assign bus.in_ready = rdy_en && (count != FULL_COUNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !fifo_empty && (!bus.out_valid || bus.out_ready);
  assign bus.out_valid = (state == S_FULL);

  assign head_a    = fifo_empty ? 32'h0 : mem_a[rd_ptr];
  assign head_b    = fifo_empty ? 32'h0 : mem_b[rd_ptr];
  assign bus.add_a = head_a;
  assign bus.add_b = head_b;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= bus.in_a;
      mem_b[wr_ptr]   <= bus.in_b;
      mem_tag[wr_ptr] <= bus.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Special cases are checked in priority order; only the final branch trusts the adder.
  always_comb begin
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (head_a[30:23] == 8'h00);
    b_zero = (head_b[30:23] == 8'h00);
    a_inf  = (head_a[30:23] == 8'hFF) && (head_a[22:0] == 23'h0);
    b_inf  = (head_b[30:23] == 8'hFF) && (head_b[22:0] == 23'h0);
    a_nan  = (head_a[30:23] == 8'hFF) && (head_a[22:0] != 23'h0);
    b_nan  = (head_b[30:23] == 8'hFF) && (head_b[22:0] != 23'h0);
    sel_result = bus.add_sum;
    sel_flags  = {1'b0, (bus.add_sum[30:23] == 8'hFF), (bus.add_sum[30:23] == 8'h00), 1'b0};
    if (a_nan || b_nan || (a_inf && b_inf && (head_a[31] != head_b[31]))) begin
      sel_result = 32'h7FC0_0000;
      sel_flags  = 4'b1001;
    end else if (a_inf) begin
      sel_result = head_a;
      sel_flags  = 4'b0101;
    end else if (b_inf) begin
      sel_result = head_b;
      sel_flags  = 4'b0101;
    end else if (a_zero && b_zero) begin
      sel_result = {head_a[31] & head_b[31], 31'h0};
      sel_flags  = 4'b0011;
    end else if (a_zero) begin
      sel_result = head_b;
      sel_flags  = 4'b0001;
    end else if (b_zero) begin
      sel_result = head_a;
      sel_flags  = 4'b0001;
    end else if ((head_a[30:0] == head_b[30:0]) && (head_a[31] != head_b[31])) begin
      sel_result = 32'h0000_0000;
      sel_flags  = 4'b0011;
    end
  end

  // Output side: a load refills the register whenever it is empty or being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_EMPTY;
      bus.out_result <= '0;
      bus.out_tag    <= '0;
      bus.out_flags  <= '0;
    end else begin
      if (pop) begin
        bus.out_result <= sel_result;
        bus.out_tag    <= mem_tag[rd_ptr];
        bus.out_flags  <= sel_flags;
      end
      case (state)
        S_EMPTY: if (pop) state <= S_FULL;
        S_FULL:  if (!pop && bus.out_ready) state <= S_EMPTY;
        default: state <= S_EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_issue.sv
// Bench for fp_add_issue: behavioural adder plus rule-based reference model and an expected-result queue.
module tb_fp_add_issue;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    logic [3:0]  flags;
  } exp_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  bit   last_accepted;
  exp_t exp_q[$];

  fp_add_issue_if #(.TAG_W(4)) bus ();

  fp_add_issue #(.DEPTH(4), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real to_real(input logic [31:0] f);
    logic [63:0] bits;
    if (f[30:23] == 8'h00) return 0.0;
    bits = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'h0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [31:0] from_real(input real r);
    logic [63:0] bits;
    int e;
    bits = $realtobits(r);
    if (bits[62:52] == 11'h0) return 32'h0;
    e = int'(bits[62:52]) - 1023 + 127;
    if (e >= 255) return {bits[63], 8'hFF, 23'h0};
    if (e <= 0) return {bits[63], 31'h0};
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return from_real(to_real(a) + to_real(b));
  endfunction

  always_comb bus.add_sum = fadd(bus.add_a, bus.add_b);

  // Expected {flags, result} from the IEEE special-case rules, falling back to the adder.
  function automatic logic [35:0] ref_model(input logic [31:0] a, input logic [31:0] b);
    bit za, zb, ia, ib, na, nb;
    logic [31:0] s;
    za = (a[30:23] == 0);
    zb = (b[30:23] == 0);
    ia = (a[30:23] == 255) && (a[22:0] == 0);
    ib = (b[30:23] == 255) && (b[22:0] == 0);
    na = (a[30:23] == 255) && (a[22:0] != 0);
    nb = (b[30:23] == 255) && (b[22:0] != 0);
    if (na || nb || (ia && ib && a[31] != b[31])) return {4'b1001, 32'h7FC00000};
    if (ia) return {4'b0101, a};
    if (ib) return {4'b0101, b};
    if (za && zb) return {4'b0011, a[31] & b[31], 31'h0};
    if (za) return {4'b0001, b};
    if (zb) return {4'b0001, a};
    if (a[30:0] == b[30:0] && a[31] != b[31]) return {4'b0011, 32'h0};
    s = fadd(a, b);
    return {1'b0, s[30:23] == 8'hFF, s[30:23] == 8'h00, 1'b0, s};
  endfunction

  function automatic logic [31:0] gen_normal();
    logic [31:0] m;
    int e;
    m = $urandom;
    e = ($urandom_range(0, 15) == 0) ? $urandom_range(250, 254) : $urandom_range(110, 140);
    return {1'($urandom_range(0, 1)), e[7:0], m[22:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", name, observed, expected);
    end
  endtask

  // Drives one cycle from a negedge; scores any result handed over and records any accepted pair.
  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] tag, input bit ordy, input bit use_model,
                               input logic [31:0] er, input logic [3:0] ef);
    exp_t e;
    logic [35:0] m;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
    if (bus.out_valid && bus.out_ready) begin
      checkOutput("result_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("out_result", bus.out_result, e.res);
        checkOutput("out_tag", 32'(bus.out_tag), 32'(e.tag));
        checkOutput("out_flags", 32'(bus.out_flags), 32'(e.flags));
      end
    end
    last_accepted = v && bus.in_ready;
    if (last_accepted) begin
      if (use_model) begin
        m = ref_model(a, b);
        e.res = m[31:0];
        e.flags = m[35:32];
      end else begin
        e.res = er;
        e.flags = ef;
      end
      e.tag = tag;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] dir_a [10];
    logic [31:0] dir_b [10];
    logic [31:0] dir_r [10];
    logic [3:0]  dir_f [10];
    logic [31:0] pa, pb;
    logic [3:0]  ptag;
    int acc, cyc;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b0;

    #12;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_result", bus.out_result, 32'd0);
    checkOutput("reset_out_tag", 32'(bus.out_tag), 32'd0);
    checkOutput("reset_out_flags", 32'(bus.out_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("in_ready_after_release", 32'(bus.in_ready), 32'd1);

    // Two-cycle latency on a single 1.0 + 2.0.
    applyStimulus(1, 32'h3F800000, 32'h40000000, 4'd5, 1, 0, 32'h40400000, 4'b0000);
    checkOutput("latency_not_yet", 32'(bus.out_valid), 32'd0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("latency_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("latency_drained", 32'(exp_q.size()), 32'd0);

    dir_a = '{32'h7F800000, 32'h7F800000, 32'h80000000, 32'h40490FDB, 32'h7FC00001,
              32'h00000000, 32'h3F800000, 32'h7F7FFFFF, 32'hFF800000, 32'h3F800000};
    dir_b = '{32'hFF800000, 32'h3F800000, 32'h80000000, 32'hC0490FDB, 32'h3F800000,
              32'hC0000000, 32'h00000001, 32'h7F7FFFFF, 32'hBF800000, 32'h40000000};
    dir_r = '{32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h00000000, 32'h7FC00000,
              32'hC0000000, 32'h3F800000, 32'h7F800000, 32'hFF800000, 32'h40400000};
    dir_f = '{4'b1001, 4'b0101, 4'b0011, 4'b0011, 4'b1001,
              4'b0001, 4'b0001, 4'b0100, 4'b0101, 4'b0000};
    for (int i = 0; i < 10; i++)
      applyStimulus(1, dir_a[i], dir_b[i], 4'(i), 1, 0, dir_r[i], dir_f[i]);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("directed_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: four in the FIFO plus one held in the output register.
    acc = 0;
    ptag = 4'd0;
    pa = gen_normal();
    pb = gen_normal();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, pa, pb, ptag, 0, 1, 0, 0);
      if (last_accepted) begin
        acc++;
        ptag++;
        pa = gen_normal();
        pb = gen_normal();
      end
    end
    checkOutput("bp_accepted", 32'(acc), 32'd5);
    checkOutput("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with work queued must drop everything.
    for (int i = 0; i < 4; i++) applyStimulus(1, gen_normal(), gen_normal(), 4'(i), 0, 1, 0, 0);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("midreset_no_stale", 32'(bus.out_valid), 32'd0);

    // Random traffic with random backpressure.
    acc = 0;
    cyc = 0;
    ptag = 4'd0;
    pa = gen_normal();
    pb = ($urandom_range(0, 15) == 0) ? {~pa[31], pa[30:0]} : gen_normal();
    while (acc < 1000 && cyc < 20000) begin
      applyStimulus($urandom_range(0, 3) != 0, pa, pb, ptag, 1'($urandom_range(0, 1)), 1, 0, 0);
      cyc++;
      if (last_accepted) begin
        acc++;
        ptag++;
        pa = gen_normal();
        pb = ($urandom_range(0, 15) == 0) ? {~pa[31], pa[30:0]} : gen_normal();
      end
    end
    checkOutput("random_all_sent", 32'(acc), 32'd1000);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
      cyc++;
    end
    checkOutput("random_none_lost", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
